vga_line_fetch: RTL and testbench

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

---
 rtl/vga_line_fetch.sv | 159 +++++++++++++++
 tb/tb_vga_line_fetch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// Fetches one 1024-pixel framebuffer line from DDR3 through the MIG read port into line buffer A or B.
// Define FETCH_STAT_EN to build the saturating underrun counter; otherwise underrun_cnt is tied to 0.
module vga_line_fetch #(
  parameter logic [29:0] FB_BASE   = 30'h0000000,
  parameter int          BURST_LEN = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        read_line_req,
  input  logic        read_line_A_B,
  input  logic [15:0] read_line_addr,
  output logic        read_line_ack,
  output logic        c3_p1_cmd_en,
  input  logic        c3_p1_cmd_full,
  output logic        c3_p1_cmd_rw,
  output logic [5:0]  c3_p1_cmd_bl,
  output logic [29:0] c3_p1_cmd_byte_addr,
  output logic        c3_p1_rd_en,
  input  logic [31:0] c3_p1_rd_data,
  input  logic        c3_p1_rd_empty,
  output logic [15:0] buffAB_wrdata,
  output logic [9:0]  buffAB_wraddress,
  output logic        buffA_wren,
  output logic        buffB_wren,
  output logic [15:0] underrun_cnt
);

  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic [2:0] {IDLE, CMD, DATA, HI, DONE} state_t;
  state_t state, state_n;

  logic        req_s1, req_s2, req_d;
  logic        req_rise;
  logic [15:0] line;
  logic        sel_a;
  logic [8:0]  word;
  logic [31:0] rd_latch;
  logic        burst_end, last_word;
  logic        issue_cmd, take_word, write_hi, set_ack, clr_ack;

  assign req_rise  = req_s2 & ~req_d;
  assign burst_end = (word[BW-1:0] == {BW{1'b1}});
  assign last_word = (word == 9'd511);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
      req_d  <= 1'b0;
      state  <= IDLE;
    end else begin
      req_s1 <= read_line_req;
      req_s2 <= req_s1;
      req_d  <= req_s2;
      state  <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    issue_cmd = 1'b0;
    take_word = 1'b0;
    write_hi  = 1'b0;
    set_ack   = 1'b0;
    clr_ack   = 1'b0;
    case (state)
      IDLE: if (req_rise) state_n = CMD;
      CMD: begin
        if (!c3_p1_cmd_full) begin
          issue_cmd = 1'b1;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (!c3_p1_rd_empty) begin
          take_word = 1'b1;
          state_n   = HI;
        end
      end
      HI: begin
        write_hi = 1'b1;
        if (!burst_end)     state_n = DATA;
        else if (last_word) state_n = DONE;
        else                state_n = CMD;
      end
      DONE: begin
        // A request already gone by the time the line lands is an underrun: leave without ack.
        if (req_s2) begin
          set_ack = 1'b1;
        end else begin
          clr_ack = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      line                <= '0;
      sel_a               <= 1'b0;
      word                <= '0;
      rd_latch            <= '0;
      read_line_ack       <= 1'b0;
      c3_p1_cmd_en        <= 1'b0;
      c3_p1_cmd_rw        <= 1'b0;
      c3_p1_cmd_bl        <= '0;
      c3_p1_cmd_byte_addr <= '0;
      c3_p1_rd_en         <= 1'b0;
      buffAB_wrdata       <= '0;
      buffAB_wraddress    <= '0;
      buffA_wren          <= 1'b0;
      buffB_wren          <= 1'b0;
    end else begin
      c3_p1_cmd_en <= issue_cmd;
      c3_p1_rd_en  <= take_word;
      buffA_wren   <= (take_word | write_hi) & sel_a;
      buffB_wren   <= (take_word | write_hi) & ~sel_a;
      if (state == IDLE && req_rise) begin
        line  <= read_line_addr;
        sel_a <= read_line_A_B;
        word  <= '0;
      end
      // word counts 32-bit words of the line, so word*4 is also the burst byte offset.
      if (issue_cmd) begin
        c3_p1_cmd_rw        <= 1'b1;
        c3_p1_cmd_bl        <= 6'(BURST_LEN - 1);
        c3_p1_cmd_byte_addr <= FB_BASE + {3'b000, line, 11'b0} + {19'b0, word, 2'b00};
      end
      if (take_word) begin
        rd_latch         <= c3_p1_rd_data;
        buffAB_wrdata    <= c3_p1_rd_data[15:0];
        buffAB_wraddress <= {word, 1'b0};
      end
      if (write_hi) begin
        buffAB_wrdata    <= rd_latch[31:16];
        buffAB_wraddress <= {word, 1'b1};
        word             <= word + 9'd1;
      end
      if (set_ack)      read_line_ack <= 1'b1;
      else if (clr_ack) read_line_ack <= 1'b0;
    end
  end

`ifdef FETCH_STAT_EN
  logic underrun;
  assign underrun = (state == DONE) && !req_s2 && !read_line_ack;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                                underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: MIG FIFO model, write scoreboard, command address checks.
// A second instance with a high FB_BASE observes address wrap-around.
module tb_vga_line_fetch;
  localparam int BL = 32;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        read_line_req, read_line_A_B;
  logic [15:0] read_line_addr;
  logic        cmd_full, rd_empty;
  logic [31:0] rd_data;

  logic        ack, cmd_en, cmd_rw, rd_en, wren_a, wren_b;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_addr;
  logic [15:0] wrdata, urun;
  logic [9:0]  wraddr;

  logic        w_ack, w_cmd_en, w_cmd_rw, w_rd_en, w_wren_a, w_wren_b;
  logic [5:0]  w_cmd_bl;
  logic [29:0] w_cmd_addr;
  logic [15:0] w_wrdata, w_urun;
  logic [9:0]  w_wraddr;

  always #5 sys_clk = ~sys_clk;

  vga_line_fetch #(.FB_BASE(30'h0000000), .BURST_LEN(BL)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .read_line_req(read_line_req), .read_line_A_B(read_line_A_B),
    .read_line_addr(read_line_addr), .read_line_ack(ack),
    .c3_p1_cmd_en(cmd_en), .c3_p1_cmd_full(cmd_full), .c3_p1_cmd_rw(cmd_rw),
    .c3_p1_cmd_bl(cmd_bl), .c3_p1_cmd_byte_addr(cmd_addr),
    .c3_p1_rd_en(rd_en), .c3_p1_rd_data(rd_data), .c3_p1_rd_empty(rd_empty),
    .buffAB_wrdata(wrdata), .buffAB_wraddress(wraddr),
    .buffA_wren(wren_a), .buffB_wren(wren_b), .underrun_cnt(urun)
  );

  vga_line_fetch #(.FB_BASE(30'h3FFFF800), .BURST_LEN(BL)) dut_w (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .read_line_req(read_line_req), .read_line_A_B(read_line_A_B),
    .read_line_addr(read_line_addr), .read_line_ack(w_ack),
    .c3_p1_cmd_en(w_cmd_en), .c3_p1_cmd_full(cmd_full), .c3_p1_cmd_rw(w_cmd_rw),
    .c3_p1_cmd_bl(w_cmd_bl), .c3_p1_cmd_byte_addr(w_cmd_addr),
    .c3_p1_rd_en(w_rd_en), .c3_p1_rd_data(rd_data), .c3_p1_rd_empty(rd_empty),
    .buffAB_wrdata(w_wrdata), .buffAB_wraddress(w_wraddr),
    .buffA_wren(w_wren_a), .buffB_wren(w_wren_b), .underrun_cnt(w_urun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] data_of(input int unsigned n);
    logic [15:0] v;
    v = n[15:0];
    return (n == 0) ? 32'hBEEF_1234 : {v ^ 16'h5A5A, v};
  endfunction

  // MIG model: each accepted command queues BL words; rd_en pops the head.
  logic [31:0] mig_q[$];
  logic [25:0] exp_q[$];
  logic [31:0] exp_cmd_q[$];
  logic [31:0] md;
  int unsigned word_n = 0;
  int          exp_word = 0;
  int          pop_viol = 0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mig_q.delete();
      rd_empty <= 1'b1;
      rd_data  <= '0;
    end else begin
      if (rd_en) begin
        if (mig_q.size() > 0) void'(mig_q.pop_front());
        else pop_viol++;
      end
      if (cmd_en && !cmd_full) begin
        for (int i = 0; i < BL; i++) begin
          md = data_of(word_n);
          mig_q.push_back(md);
          exp_q.push_back({10'(2 * exp_word), md[15:0]});
          exp_q.push_back({10'(2 * exp_word + 1), md[31:16]});
          word_n++;
          exp_word++;
        end
      end
      rd_empty <= (mig_q.size() == 0);
      rd_data  <= (mig_q.size() > 0) ? mig_q[0] : 32'h0;
    end
  end

  int          cmd_cnt, wr_cnt, a_cnt, b_cnt, rd_viol, both_viol, full_viol;
  logic        ack_seen, exp_sel, rd_en_prev, w_seen;
  logic [29:0] last_cmd_addr, w_first;
  logic [9:0]  fw_addr[2];
  logic [15:0] fw_data[2];
  logic [25:0] we;
  logic [31:0] ce;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (rd_en && rd_empty) rd_viol++;
      if (rd_en && rd_en_prev) rd_viol++;
      rd_en_prev = rd_en;
      if (cmd_en && cmd_full) full_viol++;
      if (cmd_en) begin
        cmd_cnt++;
        last_cmd_addr = cmd_addr;
        ce = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 32'hFFFF_FFFF;
        check("cmd_addr", {2'b00, cmd_addr}, ce);
        check("cmd_bl", cmd_bl, 31);
        check("cmd_rw", cmd_rw, 1);
      end
      if (w_cmd_en && !w_seen) begin
        w_first = w_cmd_addr;
        w_seen  = 1'b1;
      end
      if (wren_a && wren_b) both_viol++;
      if (wren_a || wren_b) begin
        if (wr_cnt < 2) begin
          fw_addr[wr_cnt] = wraddr;
          fw_data[wr_cnt] = wrdata;
        end
        wr_cnt++;
        if (wren_a) a_cnt++;
        else b_cnt++;
        we = (exp_q.size() > 0) ? exp_q.pop_front() : 26'h3FF_FFFF;
        check("wr_addr_data", {wraddr, wrdata}, we);
        check("wr_sel", wren_a, exp_sel);
      end
      if (ack) ack_seen = 1'b1;
    end
  end

  task automatic start_line(input logic [15:0] line, input logic ab);
    cmd_cnt = 0; wr_cnt = 0; a_cnt = 0; b_cnt = 0;
    rd_viol = 0; both_viol = 0; full_viol = 0; pop_viol = 0;
    ack_seen = 1'b0; w_seen = 1'b0; rd_en_prev = 1'b0;
    exp_q.delete(); exp_cmd_q.delete(); exp_word = 0;
    exp_sel = ab;
    for (int k = 0; k < 16; k++) exp_cmd_q.push_back(32'(line) * 2048 + k * 128);
    read_line_addr = line;
    read_line_A_B  = ab;
    read_line_req  = 1'b1;
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ack) break;
      @(negedge sys_clk);
    end
    check("ack_wait", ack, 1);
  endtask

  task automatic drop_req();
    read_line_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!ack) break;
      @(negedge sys_clk);
    end
    check("ack_clear", ack, 0);
  endtask

  task automatic line_checks(input int exp_a, input int exp_b);
    check("cmd_count", cmd_cnt, 16);
    check("wr_count_a", a_cnt, exp_a);
    check("wr_count_b", b_cnt, exp_b);
    check("exp_left", exp_q.size(), 0);
    check("cmd_left", exp_cmd_q.size(), 0);
    check("rd_en_rule", rd_viol + pop_viol, 0);
    check("wren_both", both_viol, 0);
    check("cmd_while_full", full_viol, 0);
  endtask

  initial begin
    sys_rst = 1'b1; read_line_req = 1'b0; read_line_A_B = 1'b0;
    read_line_addr = '0; cmd_full = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_cmd_en", cmd_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wren", {wren_a, wren_b}, 0);
    check("rst_ack", ack, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_underrun", urun, 0);

    // Line 3 into buffer A; first command lands on the 4th edge.
    start_line(16'd3, 1'b1);
    repeat (3) @(posedge sys_clk);
    #1 check("cmd_edge3", cmd_en, 0);
    @(posedge sys_clk);
    #1 check("cmd_edge4", cmd_en, 1);
    @(negedge sys_clk);
    wait_ack(4000);
    line_checks(1024, 0);
    check("first_lo_addr", fw_addr[0], 0);
    check("first_lo_data", fw_data[0], 16'h1234);
    check("first_hi_addr", fw_addr[1], 1);
    check("first_hi_data", fw_data[1], 16'hBEEF);
    drop_req();
    check("no_underrun", urun, 0);

    // cmd_full held across burst 5 of line 1 into buffer B.
    @(negedge sys_clk);
    start_line(16'd1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (cmd_cnt >= 5) break;
      @(negedge sys_clk);
    end
    cmd_full = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (wr_cnt >= 5 * 2 * BL) break;
      @(negedge sys_clk);
    end
    repeat (20) @(negedge sys_clk);
    check("full_hold_cmds", cmd_cnt, 5);
    cmd_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_cnt >= 6) break;
      @(negedge sys_clk);
    end
    check("burst5_addr", last_cmd_addr, 2048 + 640);
    wait_ack(4000);
    line_checks(0, 1024);
    drop_req();

    // Request dropped after burst 2: full drain, no ack, underrun.
    @(negedge sys_clk);
    start_line(16'd2, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      if (cmd_cnt >= 3) break;
      @(negedge sys_clk);
    end
    read_line_req = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (wr_cnt >= 1024) break;
      @(negedge sys_clk);
    end
    repeat (10) @(negedge sys_clk);
    line_checks(1024, 0);
    check("underrun_no_ack", ack_seen, 0);
`ifdef FETCH_STAT_EN
    check("underrun_cnt", urun, 1);
`else
    check("underrun_cnt", urun, 0);
`endif

    // Reset pulse in mid-line, then a clean restart from burst 0.
    @(negedge sys_clk);
    start_line(16'd5, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (wr_cnt >= 100) break;
      @(negedge sys_clk);
    end
    #2 sys_rst = 1'b1;
    #1;
    check("mid_rst_cmd_en", cmd_en, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_wren", {wren_a, wren_b}, 0);
    check("mid_rst_wr", {wraddr, wrdata}, 0);
    check("mid_rst_addr", cmd_addr, 0);
    read_line_req = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    start_line(16'd5, 1'b0);
    wait_ack(4000);
    line_checks(0, 1024);
    drop_req();

    // Top line number: base + line*2048 wraps modulo 2^30 in the high-base instance.
    @(negedge sys_clk);
    start_line(16'hFFFF, 1'b1);
    wait_ack(4000);
    line_checks(1024, 0);
    check("wrap_first_addr", w_first, 30'h07FFF000);
    drop_req();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
